piso_tx: RTL and testbench

Parallel-in, serial-out transmitter feeding the dice value link. Accepts one 7-bit word over a valid/ready handshake and emits it as a serial bit stream with a per-bit strobe, sized to drive the downstream serial-in, parallel-out receiver directly: `o_serial` → receiver data input, `o_strobe` → receiver start/bit strobe. Each frame is one start slot followed by the data bits LSB first, then a guard gap. The gap lets the receiver pass through its done state before the next frame begins.

---
 rtl/dice_serial_pkg.sv | 22 ++
 rtl/piso_tx_if.sv | 28 ++
 rtl/piso_tx_bit_timer.sv | 41 ++++
 rtl/piso_tx.sv | 155 +++++++++++++++
 tb/tb_piso_tx.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dice_serial_pkg.sv
// Shared types and constants for the dice value serial link (transmitter and receiver).
package dice_serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } dice_state_e;

    localparam int DICE_DATA_W = 7;
    localparam int DICE_MIN_GAP = 2;

    // One start slot plus the data slots, followed by the guard gap.
    function automatic int frame_cycles(input int data_w, input int cycles_per_bit,
                                        input int gap_cycles);
        return (data_w + 1) * cycles_per_bit + gap_cycles;
    endfunction

    localparam int DICE_FRAME_CYCLES_DEF = (DICE_DATA_W + 1) * 1 + DICE_MIN_GAP;

endpackage

// File: rtl/piso_tx_if.sv
// Word-in / serial-out bus of piso_tx, with the FSM state brought out for observation.
interface piso_tx_if
    import dice_serial_pkg::*;
#(
    parameter int DATA_W = DICE_DATA_W
);
    // A word moves on a rising edge where i_valid && o_ready; i_data must be stable
    // while i_valid is high and o_ready is low, and may change freely after the transfer.
    logic [DATA_W-1:0] i_data;
    logic              i_valid;
    logic              o_ready;
    logic              o_serial;
    logic              o_strobe;
    logic              o_busy;
    logic              o_done;
    dice_state_e       state_dbg;

    modport slave (
        input  i_data, i_valid,
        output o_ready, o_serial, o_strobe, o_busy, o_done, state_dbg
    );

    modport master (
        output i_data, i_valid,
        input  o_ready, o_serial, o_strobe, o_busy, o_done, state_dbg
    );

endinterface

// File: rtl/piso_tx_bit_timer.sv
// Slot timer: counts clock cycles within one bit slot and flags the slot's last cycle.
module bit_timer #(
    parameter int CYCLES_PER_BIT = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic tick,
    output logic tick_nx
);

    localparam int CW = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CYCLES_PER_BIT - 1);

    logic [CW-1:0] count;
    logic [CW-1:0] count_nx;

    assign tick = (count == LAST);

    always_comb begin
        count_nx = count;
        if (clear) begin
            count_nx = '0;
        end else if (enable) begin
            count_nx = tick ? '0 : count + 1'b1;
        end
    end

    // Lets the owner register its strobe one cycle ahead of the slot end.
    assign tick_nx = (count_nx == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else begin
            count <= count_nx;
        end
    end

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: start slot, DATA_W bits LSB first, guard gap.
// Define PISO_TX_SKID_EN to add a one-word holding buffer for back-to-back frames.
module piso_tx
    import dice_serial_pkg::*;
#(
    parameter int CYCLES_PER_BIT = 1,
    parameter int DATA_W         = DICE_DATA_W,
    parameter int GAP_CYCLES     = DICE_MIN_GAP
) (
    input  logic clk,
    input  logic reset_n,
    piso_tx_if.slave bus
);

    localparam int BW = $clog2(DATA_W + 1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    dice_state_e       state, state_nx;
    logic [DATA_W-1:0] sr, sr_nx;
    logic [BW-1:0]     bit_cnt, bit_cnt_nx;
    logic [GW-1:0]     gap_cnt, gap_cnt_nx;
    logic              serial_q, strobe_q, busy_q, done_q;
    logic              tmr_clear, tmr_en, tick, tick_nx;
    logic              ready, hs, gap_end;

`ifdef PISO_TX_SKID_EN
    logic              buf_full, buf_full_nx;
    logic [DATA_W-1:0] buf_data, buf_data_nx;
    assign ready = !buf_full;
`else
    assign ready = (state == ST_IDLE);
`endif

    assign hs      = bus.i_valid && ready;
    assign gap_end = (state == ST_GAP) && (gap_cnt == GAP_LAST);

    bit_timer #(.CYCLES_PER_BIT(CYCLES_PER_BIT)) u_bit_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (tmr_clear),
        .enable  (tmr_en),
        .tick    (tick),
        .tick_nx (tick_nx)
    );

    always_comb begin
        state_nx   = state;
        sr_nx      = sr;
        bit_cnt_nx = bit_cnt;
        gap_cnt_nx = gap_cnt;
        tmr_clear  = 1'b0;
        tmr_en     = (state == ST_START) || (state == ST_SHIFT);
`ifdef PISO_TX_SKID_EN
        buf_full_nx = buf_full;
        buf_data_nx = buf_data;
`endif
        case (state)
            ST_IDLE: begin
                if (hs) begin
                    state_nx  = ST_START;
                    sr_nx     = bus.i_data;
                    tmr_clear = 1'b1;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_nx   = ST_SHIFT;
                    bit_cnt_nx = '0;
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    sr_nx      = sr >> 1;
                    bit_cnt_nx = bit_cnt + 1'b1;
                    if (bit_cnt == BIT_LAST) begin
                        state_nx   = ST_GAP;
                        gap_cnt_nx = '0;
                    end
                end
            end
            ST_GAP: begin
                if (gap_end) begin
                    state_nx = ST_IDLE;
`ifdef PISO_TX_SKID_EN
                    // A buffered word wins; otherwise a word offered right now starts directly.
                    if (buf_full) begin
                        state_nx    = ST_START;
                        sr_nx       = buf_data;
                        tmr_clear   = 1'b1;
                        buf_full_nx = 1'b0;
                    end else if (hs) begin
                        state_nx  = ST_START;
                        sr_nx     = bus.i_data;
                        tmr_clear = 1'b1;
                    end
`endif
                end else begin
                    gap_cnt_nx = gap_cnt + 1'b1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
`ifdef PISO_TX_SKID_EN
        if (hs && (state != ST_IDLE) && !gap_end) begin
            buf_full_nx = 1'b1;
            buf_data_nx = bus.i_data;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            sr       <= '0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
            serial_q <= 1'b0;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nx;
            sr       <= sr_nx;
            bit_cnt  <= bit_cnt_nx;
            gap_cnt  <= gap_cnt_nx;
            // Outputs are computed from next-state values so they line up with the state.
            serial_q <= (state_nx == ST_SHIFT) && sr_nx[0];
            strobe_q <= ((state_nx == ST_START) || (state_nx == ST_SHIFT)) && tick_nx;
            busy_q   <= (state_nx != ST_IDLE);
            done_q   <= (state_nx == ST_GAP) && (gap_cnt_nx == GAP_LAST);
        end
    end

`ifdef PISO_TX_SKID_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_full <= 1'b0;
            buf_data <= '0;
        end else begin
            buf_full <= buf_full_nx;
            buf_data <= buf_data_nx;
        end
    end
`endif

    assign bus.o_ready   = ready;
    assign bus.o_serial  = serial_q;
    assign bus.o_strobe  = strobe_q;
    assign bus.o_busy    = busy_q;
    assign bus.o_done    = done_q;
    assign bus.state_dbg = state;

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: CYCLES_PER_BIT 1, 4 and 256 instances, behavioural receiver on the 4-cycle one.
module tb_piso_tx;
    import dice_serial_pkg::*;

    localparam int DW = DICE_DATA_W;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    piso_tx_if #(.DATA_W(DW)) b1 ();
    piso_tx_if #(.DATA_W(DW)) b4 ();
    piso_tx_if #(.DATA_W(DW)) b256 ();

    piso_tx #(.CYCLES_PER_BIT(1), .DATA_W(DW), .GAP_CYCLES(2)) u1 (
        .clk(clk), .reset_n(reset_n), .bus(b1));
    piso_tx #(.CYCLES_PER_BIT(4), .DATA_W(DW), .GAP_CYCLES(2)) u4 (
        .clk(clk), .reset_n(reset_n), .bus(b4));
    piso_tx #(.CYCLES_PER_BIT(256), .DATA_W(DW), .GAP_CYCLES(2)) u256 (
        .clk(clk), .reset_n(reset_n), .bus(b256));

    // Receiver model: first strobe leaves idle, each later strobe shifts in at the MSB.
    logic          rx_active;
    int            rx_cnt;
    logic [DW-1:0] rx_sr;
    logic [DW-1:0] got_q[$];
    logic [DW-1:0] exp_q[$];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_active <= 1'b0;
            rx_cnt    <= 0;
            rx_sr     <= '0;
        end else if (b4.o_strobe) begin
            if (!rx_active) begin
                rx_active <= 1'b1;
                rx_cnt    <= 0;
            end else begin
                rx_sr <= {b4.o_serial, rx_sr[DW-1:1]};
                if (rx_cnt == DW - 1) begin
                    got_q.push_back({b4.o_serial, rx_sr[DW-1:1]});
                    rx_active <= 1'b0;
                end else begin
                    rx_cnt <= rx_cnt + 1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_rx();
        while (exp_q.size() > 0) begin
            logic [DW-1:0] e;
            e = exp_q.pop_front();
            if (got_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_word actual=none required=%0h", e);
            end else begin
                check("rx_word", 32'(got_q.pop_front()), 32'(e));
            end
        end
        check("rx_extra", got_q.size(), 0);
    endtask

    // Returns c0 = cycle count in cycle T+1, so cycle T+k has cyc == c0 + k - 1.
    task automatic send4(input logic [DW-1:0] d, output int c0);
        int n;
        n = 0;
        @(negedge clk);
        while (!b4.o_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("send4_ready", b4.o_ready, 1);
        b4.i_valid = 1'b1;
        b4.i_data  = d;
        @(posedge clk);
        #1;
        b4.i_valid = 1'b0;
        c0 = cyc;
    endtask

    task automatic monitor4(input int c0, output int first_k, output int done_k, output int nstb);
        bit seen;
        first_k = -1;
        done_k  = -1;
        nstb    = 0;
        seen    = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (b4.o_strobe) begin
                if (first_k < 0) first_k = cyc - c0 + 1;
                nstb++;
            end
            if (b4.o_done) begin
                done_k = cyc - c0 + 1;
                seen   = 1;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL monitor4_timeout done=0 required=1");
        end
    endtask

    task automatic wait_done4();
        bit seen;
        seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (b4.o_done) seen = 1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL wait_done4_timeout done=0 required=1");
        end
    endtask

    typedef struct {
        logic          valid;
        logic [DW-1:0] data;
        logic [4:0]    exp;   // {ready, serial, strobe, busy, done}
    } vec_t;

    vec_t vt[12];

    initial begin
        int c0, fk, dk, ns, viol, cnt;
        bit seen;
        int stb_k[$];

        b1.i_valid = 1'b0;   b1.i_data = '0;
        b4.i_valid = 1'b0;   b4.i_data = '0;
        b256.i_valid = 1'b0; b256.i_data = '0;

        // 7'h55 with one cycle per bit: start slot then 1,0,1,0,1,0,1.
        vt[0]  = '{1'b1, 7'h55, 5'b10000};
        vt[1]  = '{1'b0, 7'h00, 5'b00110};
        vt[2]  = '{1'b0, 7'h00, 5'b01110};
        vt[3]  = '{1'b0, 7'h00, 5'b00110};
        vt[4]  = '{1'b0, 7'h00, 5'b01110};
        vt[5]  = '{1'b0, 7'h00, 5'b00110};
        vt[6]  = '{1'b0, 7'h00, 5'b01110};
        vt[7]  = '{1'b0, 7'h00, 5'b00110};
        vt[8]  = '{1'b0, 7'h00, 5'b01110};
        vt[9]  = '{1'b0, 7'h00, 5'b00010};
        vt[10] = '{1'b0, 7'h00, 5'b00011};
        vt[11] = '{1'b0, 7'h00, 5'b10000};
`ifdef PISO_TX_SKID_EN
        for (int i = 0; i < 12; i++) vt[i].exp[4] = 1'b1;
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_b1", {b1.o_ready, b1.o_serial, b1.o_strobe, b1.o_busy, b1.o_done}, 5'b10000);
        check("rst_b4", {b4.o_ready, b4.o_serial, b4.o_strobe, b4.o_busy, b4.o_done}, 5'b10000);
        check("rst_b256", {b256.o_ready, b256.o_serial, b256.o_strobe, b256.o_busy, b256.o_done}, 5'b10000);
        check("rst_state", b1.state_dbg, ST_IDLE);
        reset_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check($sformatf("vec%0d", i),
                  {b1.o_ready, b1.o_serial, b1.o_strobe, b1.o_busy, b1.o_done}, vt[i].exp);
            b1.i_valid = vt[i].valid;
            b1.i_data  = vt[i].data;
        end

`ifndef PISO_TX_SKID_EN
        // i_valid held through a frame: held off until IDLE, restart one cycle after o_done.
        @(negedge clk);
        b1.i_valid = 1'b1;
        b1.i_data  = 7'h0F;
        viol = 0;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (b1.o_busy && b1.o_ready) viol++;
            if (b1.o_done) seen = 1;
        end
        check("held_done_seen", seen, 1);
        check("held_ready_off", viol, 0);
        @(negedge clk);
        check("held_idle_cycle", {b1.state_dbg, b1.o_ready, b1.o_busy}, {ST_IDLE, 2'b10});
        @(negedge clk);
        check("held_restart", {b1.state_dbg, b1.o_busy, b1.o_strobe}, {ST_START, 2'b11});
        b1.i_valid = 1'b0;
        for (int i = 0; i < 20 && b1.o_busy; i++) @(negedge clk);
        check("held_end_idle", b1.o_busy, 0);
`endif

        // Loopback at four cycles per bit.
        send4(7'h6A, c0);
        exp_q.push_back(7'h6A);
        monitor4(c0, fk, dk, ns);
        check("first_strobe_6a", fk, 4);
        check("frame_len_6a", dk, frame_cycles(DW, 4, 2));
        check("strobe_count_6a", ns, DW + 1);
        send4(7'h01, c0);
        exp_q.push_back(7'h01);
        monitor4(c0, fk, dk, ns);
        check("frame_len_01", dk, 34);
        repeat (2) @(negedge clk);
        check_rx();

`ifdef PISO_TX_SKID_EN
        // Second word offered mid-frame goes to the buffer and follows GAP directly.
        send4(7'h11, c0);
        exp_q.push_back(7'h11);
        repeat (5) @(negedge clk);
        check("skid_ready_busy", {b4.o_busy, b4.o_ready}, 2'b11);
        b4.i_valid = 1'b1;
        b4.i_data  = 7'h3C;
        @(posedge clk);
        #1;
        b4.i_valid = 1'b0;
        exp_q.push_back(7'h3C);
        @(negedge clk);
        check("skid_full", b4.o_ready, 0);
        wait_done4();
        @(negedge clk);
        check("skid_no_idle", {b4.state_dbg, b4.o_busy, b4.o_ready}, {ST_START, 2'b11});
        wait_done4();
        repeat (2) @(negedge clk);
        check_rx();
`endif

        // Reset pulsed during the 4th data strobe.
        send4(7'h33, c0);
        cnt = 0;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (b4.o_strobe) cnt++;
            if (cnt == 5) seen = 1;
        end
        check("abort_reached", seen, 1);
        reset_n = 1'b0;
        #1;
        check("abort_outputs", {b4.o_strobe, b4.o_busy, b4.o_ready}, 3'b001);
        @(negedge clk);
        reset_n = 1'b1;
        viol = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (b4.o_strobe || b4.o_busy) viol++;
        end
        check("abort_quiet", viol, 0);
        check("abort_no_word", got_q.size(), 0);
        send4(7'h7F, c0);
        exp_q.push_back(7'h7F);
        wait_done4();
        repeat (2) @(negedge clk);
        check_rx();

        // 256 cycles per bit with 7'h00.
        @(negedge clk);
        b256.i_valid = 1'b1;
        b256.i_data  = 7'h00;
        @(posedge clk);
        #1;
        b256.i_valid = 1'b0;
        c0 = cyc;
        dk = -1;
        viol = 0;
        seen = 0;
        for (int i = 0; i < 2200 && !seen; i++) begin
            @(negedge clk);
            if (b256.o_strobe) stb_k.push_back(cyc - c0 + 1);
            if (b256.o_serial) viol++;
            if (b256.o_done) begin
                dk = cyc - c0 + 1;
                seen = 1;
            end
        end
        check("slow_strobe_count", stb_k.size(), 8);
        check("slow_serial_zero", viol, 0);
        check("slow_frame_len", dk, frame_cycles(DW, 256, 2));
        if (stb_k.size() == 8) begin
            check("slow_first_strobe", stb_k[0], 256);
            for (int i = 1; i < 8; i++)
                check($sformatf("slow_spacing%0d", i), stb_k[i] - stb_k[i-1], 256);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
